// File: rtl/btn_event_capture.sv
// Push-button conditioner: 2-FF synchroniser, per-bit debounce FSM, press-edge pulse,
// and sticky write-1-to-clear event/overrun flags for firmware polling.
module btn_event_capture #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             clr_en,
  input  logic [N_BTN-1:0] clr_mask,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_event,
  output logic [N_BTN-1:0] overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_t;

  logic [N_BTN-1:0] sync1_reg, sync2_reg;
  logic [N_BTN-1:0] level_reg, level_next;
  logic [N_BTN-1:0] pulse_reg, pulse_next;
  logic [N_BTN-1:0] event_reg, event_next;
  logic [N_BTN-1:0] overrun_reg, overrun_next;
  logic [N_BTN-1:0] clr_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
      db_state_t        state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             s2;
      logic             pulse_bit, level_bit;

      assign s2 = sync2_reg[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg <= IDLE_LO;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // Counter returns to 0 on every settle, so it never exceeds CNT_LAST.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          IDLE_LO: begin
            cnt_next = '0;
            if (s2) begin
              state_next = WAIT_HI;
              cnt_next   = CNT_ONE;
            end
          end
          WAIT_HI: begin
            if (!s2) begin
              state_next = IDLE_LO;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = IDLE_HI;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          IDLE_HI: begin
            cnt_next = '0;
            if (!s2) begin
              state_next = WAIT_LO;
              cnt_next   = CNT_ONE;
            end
          end
          WAIT_LO: begin
            if (s2) begin
              state_next = IDLE_HI;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = IDLE_LO;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = IDLE_LO;
            cnt_next   = '0;
          end
        endcase
      end

      always_comb begin
        pulse_bit = (state_reg == WAIT_HI) && s2 && (cnt_reg == CNT_LAST);
        level_bit = (state_next == IDLE_HI) || (state_next == WAIT_LO);
      end

      assign pulse_next[gi] = pulse_bit;
      assign level_next[gi] = level_bit;
    end
  endgenerate

  // A new press always wins over a same-cycle clear so no press is lost.
  always_comb begin
    clr_hit      = clr_en ? clr_mask : '0;
    event_next   = pulse_next | (event_reg & ~clr_hit);
    overrun_next = (pulse_next & event_reg & ~clr_hit) | (overrun_reg & ~clr_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_reg   <= '0;
      pulse_reg   <= '0;
      event_reg   <= '0;
      overrun_reg <= '0;
    end else begin
      level_reg   <= level_next;
      pulse_reg   <= pulse_next;
      event_reg   <= event_next;
      overrun_reg <= overrun_next;
    end
  end

  assign btn_level = level_reg;
  assign btn_pulse = pulse_reg;
  assign btn_event = event_reg;
  assign overrun   = overrun_reg;

endmodule
